apu_pulse_channel: RTL and testbench
====================================

# apu_pulse_channel

Pulse (square-wave) voice of the APU, and the consumer of the frame sequencer's `quarter_clk_en`/`half_clk_en` ticks. It decodes CPU writes to its four registers. It runs the envelope, sweep, length counter, 11-bit timer and 8-step duty sequencer, and drives a 4-bit sample to the mixer. One instance is built per pulse voice; `CHANNEL` selects the address window and the sweep negate behaviour.

## Interface
- `CHANNEL`, default 0: 0 selects pulse 1 at $4000–$4003 with ones'-complement sweep negate. 1 selects pulse 2 at $4004–$4007 with two's-complement sweep negate.
- `clk` input 1: system clock, the single clock of the block.
- `rst` input 1: reset, synchronous and active-high.
- `cpu_clk_en` input 1: CPU-rate enable. Register writes are qualified by it.
- `apu_clk_en` input 1: APU-rate enable (CPU/2). The timer advances on it.
- `quarter_clk_en` input 1: frame tick that clocks the envelope. It is asserted only in cycles where `apu_clk_en`=1.
- `half_clk_en` input 1: frame tick that clocks the length counter and sweep.
- `addr` input 16: CPU address.
- `data_in` input 8: CPU write data.
- `we` input 1: CPU write strobe.
- `length_enable` input 1: channel enable bit from $4015.
- `length_nonzero` output 1: length counter ≠ 0. Read back through $4015.
- `out` output 4: current sample, 0..15.

## Operation
- A register write occurs when `cpu_clk_en & we` and `addr` = base+n.
  - n=0: duty[7:6], halt/loop[5], const[4], V[3:0].
  - n=1: sweep en[7], P[6:4], neg[3], S[2:0]; sets the sweep reload flag.
  - n=2: timer period[7:0].
  - n=3: length index[7:3], period[10:8]. Loads the length counter from LENGTH_TABLE[index] only if `length_enable`=1. Resets the sequencer step to 0. Sets the envelope start flag.
- Timer: on `apu_clk_en`, if the timer is 0 it reloads the period and the step advances (step+1 mod 8); otherwise it decrements. The step therefore advances every period+1 APU ticks.
- Duty patterns, steps 0..7:
  - duty 0: 0,1,0,0,0,0,0,0
  - duty 1: 0,1,1,0,0,0,0,0
  - duty 2: 0,1,1,1,1,0,0,0
  - duty 3: 1,0,0,1,1,1,1,1
- Envelope, on `quarter_clk_en`:
  - If the start flag is set: clear it, set decay=15, set divider=V.
  - Else, if the divider is 0: divider=V, then decay-- if decay>0, else decay=15 if loop.
  - Else: divider--.
- Length counter, on `half_clk_en`: decrements if count>0 and halt=0. While `length_enable`=0 the count is forced to 0 every cycle.
- Sweep:
  - delta = period>>S.
  - Target: add gives period+delta. Negate gives period−delta−1 for CHANNEL 0, and period−delta for CHANNEL 1. The target is computed at 12 bits.
  - mute = (period<8) | (neg=0 & target>0x7FF). Mute is evaluated continuously, independent of the enable bit.
  - On `half_clk_en`: if divider==0 & en & S≠0 & !mute, then period=target[10:0].
  - Then, if divider==0 or reload is set: divider=P and reload is cleared; else divider--.
- Output: `out` = 0 if mute, length==0, or the duty bit is 0. Otherwise `out` = (const ? V : decay).
- Simultaneous events:
  - An n=3 write in the same cycle as a length decrement: the write wins, so the table value is loaded.
  - An n=2/n=3 write in the same cycle as a sweep period update: the write wins.
  - An n=1 write coincident with `half_clk_en`: the tick uses the old sweep settings, and reload is left set.
  - An n=3 write coincident with a timer reload: the step is set to 0.

## Timing
- All state is registered on `clk`.
- `out` and `length_nonzero` are combinational from state, so they reflect a write or tick on the following cycle.
- Reset (`rst`=1 on a clock edge):
  - All registers, the timer, the step, the envelope, the sweep divider and flags, and the length count become 0.
  - `out`=0 and `length_nonzero`=0.
  - Reset mid-operation aborts everything immediately.
- Width rules:
  - The timer is 11-bit.
  - The length count is 8-bit; 254 is the maximum.
  - Decay and divider are 4-bit, sweep divider is 3-bit, and the sweep target is 12-bit before the overflow check.

## Structure
- Package `apu_pkg` holds:
  - LENGTH_TABLE: 32×8: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - DUTY_TABLE: 4×8.
  - The base address constants 16'h4000 and 16'h4004.
- Sub-module `apu_envelope` holds the start flag, divider and decay, and is reused by the noise channel.

## Test plan
- Reset check: assert `rst` -> `out`=0, `length_nonzero`=0. Then write $4003 with `length_enable`=0 -> `length_nonzero` stays 0.
- Square wave: CHANNEL 0, `length_enable`=1. Write $4000=0xBF, $4002=0x10, $4003=0x08 -> `length_nonzero`=1 (count 254). `out` alternates 0 and 15 with 4 of 8 steps high, each step lasting 17 APU ticks.
- Length expiry: write $4000=0x10, $4003=0x00 (count 10), then give 10 half ticks -> `length_nonzero`=0 and `out`=0. Dropping `length_enable` on a loaded channel -> 0 the next cycle.
- Envelope decay: write $4000=0x02, then $4003. First quarter tick -> decay=15. Decay then decrements every 3 quarter ticks, reaches 0 and holds; with $4000=0x22 it wraps to 15.
- Sweep negate: period 0x100, $4001=0x89.
  - CHANNEL 0: half tick -> period 0x07F.
  - CHANNEL 1: half tick -> period 0x080.
- Sweep overflow: period 0x600, $4001=0x81 -> mute, `out`=0, and the period is unchanged after the half tick.

Source files
------------

// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared APU tables, base addresses and pulse channel state types
package apu_pkg;

   localparam logic [15:0] PULSE1_BASE = 16'h4000;
   localparam logic [15:0] PULSE2_BASE = 16'h4004;

   localparam logic [7:0] LENGTH_TABLE [0:31] = '{
      8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
   };

   // Bit n of each pattern is the output level at sequencer step n.
   localparam logic [7:0] DUTY_TABLE [0:3] = '{
      8'b0000_0010,
      8'b0000_0110,
      8'b0001_1110,
      8'b1111_1001
   };

   typedef enum logic [1:0] {
      REG_CTRL  = 2'd0,
      REG_SWEEP = 2'd1,
      REG_TLO   = 2'd2,
      REG_THI   = 2'd3
   } pulse_reg_e;

   typedef struct packed {
      logic [1:0]  duty;
      logic        halt;
      logic        const_vol;
      logic [3:0]  volume;
      logic        sweep_en;
      logic [2:0]  sweep_period;
      logic        sweep_neg;
      logic [2:0]  sweep_shift;
      logic        sweep_reload;
      logic [2:0]  sweep_div;
      logic [10:0] period;
      logic [10:0] timer;
      logic [2:0]  step;
      logic [7:0]  length;
   } pulse_state_t;

endpackage

// File: rtl/apu_envelope.sv
// rtl/apu_envelope.sv - envelope generator (start flag, divider, decay level)
module apu_envelope
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       quarter_clk_en,
   input  logic       start,
   input  logic       loop_en,
   input  logic [3:0] volume,
   output logic [3:0] decay
);

   logic       start_q, start_d;
   logic [3:0] div_q, div_d;
   logic [3:0] decay_q, decay_d;

   always_comb begin
      start_d = start_q;
      div_d   = div_q;
      decay_d = decay_q;
      if (quarter_clk_en) begin
         if (start_q) begin
            start_d = 1'b0;
            decay_d = 4'hF;
            div_d   = volume;
         end else if (div_q == 4'd0) begin
            div_d = volume;
            if (decay_q != 4'd0) begin
               decay_d = decay_q - 4'd1;
            end else if (loop_en) begin
               decay_d = 4'hF;
            end
         end else begin
            div_d = div_q - 4'd1;
         end
      end
      // A start request landing on a tick is kept for the next tick.
      if (start) begin
         start_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_q <= 1'b0;
         div_q   <= 4'd0;
         decay_q <= 4'd0;
      end else begin
         start_q <= start_d;
         div_q   <= div_d;
         decay_q <= decay_d;
      end
   end

   assign decay = decay_q;

endmodule

// File: rtl/apu_pulse_channel.sv
// rtl/apu_pulse_channel.sv - pulse voice: register decode, timer, duty, sweep, length, envelope
module apu_pulse_channel
   import apu_pkg::*;
#(
   parameter int CHANNEL = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_clk_en,
   input  logic        apu_clk_en,
   input  logic        quarter_clk_en,
   input  logic        half_clk_en,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   input  logic        we,
   input  logic        length_enable,
   output logic        length_nonzero,
   output logic [3:0]  out
);

   localparam logic [15:0] BASE     = (CHANNEL == 0) ? PULSE1_BASE : PULSE2_BASE;
   localparam logic [11:0] NEG_BIAS = (CHANNEL == 0) ? 12'd1 : 12'd0;

   pulse_state_t state_q, state_d;

   logic       reg_hit;
   pulse_reg_e reg_idx;
   logic       wr_ctrl, wr_sweep, wr_tlo, wr_thi;
   logic [10:0] delta;
   logic [11:0] target;
   logic        mute;
   logic [7:0]  duty_pattern;
   logic [3:0]  env_decay;

   assign reg_hit  = cpu_clk_en & we & (addr[15:2] == BASE[15:2]);
   assign reg_idx  = pulse_reg_e'(addr[1:0]);
   assign wr_ctrl  = reg_hit & (reg_idx == REG_CTRL);
   assign wr_sweep = reg_hit & (reg_idx == REG_SWEEP);
   assign wr_tlo   = reg_hit & (reg_idx == REG_TLO);
   assign wr_thi   = reg_hit & (reg_idx == REG_THI);

   // Pulse 1 negates in ones' complement, pulse 2 in two's complement.
   always_comb begin
      delta = state_q.period >> state_q.sweep_shift;
      if (state_q.sweep_neg) begin
         target = {1'b0, state_q.period} - {1'b0, delta} - NEG_BIAS;
      end else begin
         target = {1'b0, state_q.period} + {1'b0, delta};
      end
      mute = (state_q.period < 11'd8) | (~state_q.sweep_neg & (target > 12'h7FF));
   end

   always_comb begin
      state_d = state_q;

      if (apu_clk_en) begin
         if (state_q.timer == 11'd0) begin
            state_d.timer = state_q.period;
            state_d.step  = state_q.step + 3'd1;
         end else begin
            state_d.timer = state_q.timer - 11'd1;
         end
      end

      if (half_clk_en) begin
         if ((state_q.length != 8'd0) && !state_q.halt) begin
            state_d.length = state_q.length - 8'd1;
         end
         if ((state_q.sweep_div == 3'd0) && state_q.sweep_en &&
             (state_q.sweep_shift != 3'd0) && !mute) begin
            state_d.period = target[10:0];
         end
         if ((state_q.sweep_div == 3'd0) || state_q.sweep_reload) begin
            state_d.sweep_div    = state_q.sweep_period;
            state_d.sweep_reload = 1'b0;
         end else begin
            state_d.sweep_div = state_q.sweep_div - 3'd1;
         end
      end

      // CPU writes are applied last so they override same-cycle tick updates.
      if (wr_ctrl) begin
         state_d.duty      = data_in[7:6];
         state_d.halt      = data_in[5];
         state_d.const_vol = data_in[4];
         state_d.volume    = data_in[3:0];
      end
      if (wr_sweep) begin
         state_d.sweep_en     = data_in[7];
         state_d.sweep_period = data_in[6:4];
         state_d.sweep_neg    = data_in[3];
         state_d.sweep_shift  = data_in[2:0];
         state_d.sweep_reload = 1'b1;
      end
      if (wr_tlo) begin
         state_d.period = {state_q.period[10:8], data_in};
      end
      if (wr_thi) begin
         state_d.period = {data_in[2:0], state_q.period[7:0]};
         state_d.step   = 3'd0;
         state_d.length = LENGTH_TABLE[data_in[7:3]];
      end

      if (!length_enable) begin
         state_d.length = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   apu_envelope u_envelope (
      .clk            (clk),
      .rst            (rst),
      .quarter_clk_en (quarter_clk_en),
      .start          (wr_thi),
      .loop_en        (state_q.halt),
      .volume         (state_q.volume),
      .decay          (env_decay)
   );

   assign duty_pattern   = DUTY_TABLE[state_q.duty];
   assign length_nonzero = (state_q.length != 8'd0);

   always_comb begin
      out = 4'd0;
      if (!mute && length_nonzero && duty_pattern[state_q.step]) begin
         out = state_q.const_vol ? state_q.volume : env_decay;
      end
   end

endmodule

// File: tb/tb_apu_pulse_channel.sv
// tb/tb_apu_pulse_channel.sv - directed self-checking bench for both pulse voices
module tb_apu_pulse_channel;

   logic        clk;
   logic        rst;
   logic        cpu_clk_en;
   logic        apu_clk_en;
   logic        quarter_clk_en;
   logic        half_clk_en;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic        we;
   logic        length_enable;
   logic        len_nz0, len_nz1;
   logic [3:0]  out0, out1;

   int tests_run;
   int tests_failed;
   int n;

   apu_pulse_channel #(.CHANNEL(0)) dut0 (
      .clk            (clk),
      .rst            (rst),
      .cpu_clk_en     (cpu_clk_en),
      .apu_clk_en     (apu_clk_en),
      .quarter_clk_en (quarter_clk_en),
      .half_clk_en    (half_clk_en),
      .addr           (addr),
      .data_in        (data_in),
      .we             (we),
      .length_enable  (length_enable),
      .length_nonzero (len_nz0),
      .out            (out0)
   );

   apu_pulse_channel #(.CHANNEL(1)) dut1 (
      .clk            (clk),
      .rst            (rst),
      .cpu_clk_en     (cpu_clk_en),
      .apu_clk_en     (apu_clk_en),
      .quarter_clk_en (quarter_clk_en),
      .half_clk_en    (half_clk_en),
      .addr           (addr),
      .data_in        (data_in),
      .we             (we),
      .length_enable  (length_enable),
      .length_nonzero (len_nz1),
      .out            (out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr    = a;
      data_in = d;
      we      = 1'b1;
      @(negedge clk);
      we      = 1'b0;
   endtask

   task automatic half_tick();
      half_clk_en = 1'b1;
      @(negedge clk);
      half_clk_en = 1'b0;
   endtask

   task automatic quarter_tick();
      quarter_clk_en = 1'b1;
      @(negedge clk);
      quarter_clk_en = 1'b0;
   endtask

   function automatic bit lvl(input int which);
      return (which == 0) ? (out0 != 4'd0) : (out1 != 4'd0);
   endfunction

   // Length of the next complete run of the requested level; -1 if the bound expires.
   task automatic measure_run(input int which, input bit high, input int bound, output int len);
      int guard;
      guard = 0;
      len   = 0;
      while ((lvl(which) == high) && (guard < bound)) begin
         @(negedge clk);
         guard++;
      end
      while ((lvl(which) != high) && (guard < bound)) begin
         @(negedge clk);
         guard++;
      end
      while ((lvl(which) == high) && (guard < bound)) begin
         len++;
         @(negedge clk);
         guard++;
      end
      if (guard >= bound) len = -1;
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst            = 1'b1;
      cpu_clk_en     = 1'b1;
      apu_clk_en     = 1'b1;
      quarter_clk_en = 1'b0;
      half_clk_en    = 1'b0;
      addr           = 16'h0000;
      data_in        = 8'h00;
      we             = 1'b0;
      length_enable  = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("rst_out0", 32'(out0), 32'd0);
      check_eq("rst_len0", 32'(len_nz0), 32'd0);
      check_eq("rst_out1", 32'(out1), 32'd0);
      check_eq("rst_len1", 32'(len_nz1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      wr(16'h4003, 8'h08);
      check_eq("len_disabled_load", 32'(len_nz0), 32'd0);

      // Square wave: duty 2, constant volume 15, period 16 -> 17 ticks per step
      length_enable = 1'b1;
      wr(16'h4000, 8'hBF);
      wr(16'h4002, 8'h10);
      wr(16'h4003, 8'h08);
      check_eq("sq_len_loaded", 32'(len_nz0), 32'd1);
      measure_run(0, 1'b1, 400, n);
      check_eq("sq_high_run", n, 32'd68);
      measure_run(0, 1'b0, 400, n);
      check_eq("sq_low_run", n, 32'd68);
      check_eq("sq_level", 32'(out0), 32'd15);

      // Length expiry: index 0 -> 10 half ticks
      wr(16'h4000, 8'h10);
      wr(16'h4003, 8'h00);
      check_eq("len10_loaded", 32'(len_nz0), 32'd1);
      repeat (9) half_tick();
      check_eq("len_after9", 32'(len_nz0), 32'd1);
      half_tick();
      check_eq("len_after10", 32'(len_nz0), 32'd0);
      check_eq("len_out", 32'(out0), 32'd0);
      wr(16'h4003, 8'h00);
      check_eq("len_reload", 32'(len_nz0), 32'd1);
      length_enable = 1'b0;
      @(negedge clk);
      check_eq("len_drop", 32'(len_nz0), 32'd0);
      length_enable = 1'b1;

      // Envelope: long period, duty 3 so step 0 is high; V=2 -> decrement every 3 ticks
      wr(16'h4002, 8'hFF);
      wr(16'h4003, 8'h0B);
      repeat (300) @(negedge clk);
      wr(16'h4000, 8'hC2);
      wr(16'h4003, 8'h0B);
      for (int t = 1; t <= 50; t++) begin
         int steps;
         quarter_tick();
         steps = (t - 1) / 3;
         check_eq($sformatf("env_t%0d", t), 32'(out0), (steps >= 15) ? 32'd0 : 32'(15 - steps));
      end
      wr(16'h4000, 8'hE2);
      quarter_tick();
      check_eq("env_loop_t51", 32'(out0), 32'd0);
      quarter_tick();
      check_eq("env_loop_t52", 32'(out0), 32'd15);

      // Sweep negate: period 0x100, shift 1
      wr(16'h4000, 8'hBF);
      wr(16'h4004, 8'hBF);
      wr(16'h4002, 8'h00);
      wr(16'h4006, 8'h00);
      wr(16'h4003, 8'h09);
      wr(16'h4007, 8'h09);
      wr(16'h4001, 8'h89);
      wr(16'h4005, 8'h89);
      measure_run(0, 1'b1, 3000, n);
      check_eq("sw_pre_high0", n, 32'd1028);
      half_tick();
      measure_run(0, 1'b1, 3000, n);
      check_eq("sw_neg_high0", n, 32'd512);
      measure_run(1, 1'b1, 3000, n);
      check_eq("sw_neg_high1", n, 32'd516);

      // Sweep overflow: period 0x600 + 0x300 exceeds 0x7FF -> muted, period kept
      wr(16'h4001, 8'h08);
      wr(16'h4000, 8'hFF);
      wr(16'h4002, 8'h00);
      wr(16'h4003, 8'h0E);
      repeat (500) @(negedge clk);
      wr(16'h4003, 8'h0E);
      check_eq("ovf_pre", 32'(out0), 32'd15);
      wr(16'h4001, 8'h81);
      check_eq("ovf_mute", 32'(out0), 32'd0);
      half_tick();
      check_eq("ovf_mute_after_tick", 32'(out0), 32'd0);
      wr(16'h4001, 8'h08);
      check_eq("ovf_unmute", 32'(out0), 32'd15);
      measure_run(0, 1'b0, 20000, n);
      check_eq("ovf_low_run", n, 32'd3074);

      // Reset mid-operation
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_out0", 32'(out0), 32'd0);
      check_eq("midrst_len0", 32'(len_nz0), 32'd0);
      check_eq("midrst_len1", 32'(len_nz1), 32'd0);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
